// File: rtl/jtcop_sdram_resp.sv
// Array-backed responder for the 4-bank game SDRAM request interface.
// Serves one bank at a time with round-robin arbitration and periodic refresh windows.
module jtcop_sdram_resp #(
    parameter int AW       = 18,
    parameter int LAT      = 3,
    parameter int BURST    = 2,
    parameter int RFSH     = 1024,
    parameter int RFSH_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    input  logic        ba_wr,
    input  logic [15:0] ba0_din,
    input  logic [1:0]  ba0_din_m,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read
);

    // state   | meaning
    // IDLE    | arbitrate: refresh if due, else pick next request round-robin
    // ACK     | ack strobe to the picked bank
    // WAIT    | latency countdown before the first data word
    // DATA    | burst words out (read) or single masked write
    // RFSH    | remainder of the refresh window
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACK  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_RFSH = 3'd4;

    localparam int DEPTH = 1 << AW;
    localparam int RCW   = (RFSH > 0) ? $clog2(RFSH + 1) : 1;
    localparam logic [15:0]    WAIT_LOAD = (LAT >= 2) ? 16'(LAT - 2) : 16'd0;
    localparam logic [15:0]    RFSH_LOAD = (RFSH_LEN >= 2) ? 16'(RFSH_LEN - 2) : 16'd0;
    localparam logic [RCW-1:0] RFSH_MAX  = RCW'(RFSH);

    logic [15:0]    mem [0:4*DEPTH-1];
    logic [2:0]     state;
    logic [1:0]     bank;
    logic [1:0]     ptr;
    logic [AW-1:0]  addr;
    logic           we;
    logic [15:0]    din;
    logic [1:0]     din_m;
    logic [15:0]    cnt;
    logic           beat;
    logic [RCW-1:0] rfsh_cnt;

    logic [3:0]     req;
    logic           pick_ok;
    logic [1:0]     pick_bank;
    logic [AW-1:0]  pick_addr;
    logic           rfsh_due;
    logic           last_word;
    logic [3:0]     sel;
    logic           unused_hi;

    assign req       = {ba_rd[3:1], ba_rd[0] | ba_wr};
    assign rfsh_due  = (RFSH != 0) && (rfsh_cnt == RFSH_MAX);
    assign last_word = we || (BURST == 1) || beat;
    assign sel       = 4'b0001 << bank;
    assign unused_hi = ^{ba0_addr, ba1_addr, ba2_addr, ba3_addr};

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        pick_ok   = 1'b0;
        pick_bank = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                pick_ok   = 1'b1;
                pick_bank = ptr + 2'(i);
            end
        end
    end

    always_comb begin
        case (pick_bank)
            2'd0:    pick_addr = ba0_addr[AW-1:0];
            2'd1:    pick_addr = ba1_addr[AW-1:0];
            2'd2:    pick_addr = ba2_addr[AW-1:0];
            default: pick_addr = ba3_addr[AW-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bank      <= 2'd0;
            ptr       <= 2'd0;
            addr      <= '0;
            we        <= 1'b0;
            din       <= 16'd0;
            din_m     <= 2'd0;
            cnt       <= 16'd0;
            beat      <= 1'b0;
            rfsh_cnt  <= '0;
            data_read <= 16'd0;
        end else begin
            if (rfsh_cnt != RFSH_MAX)
                rfsh_cnt <= rfsh_cnt + RCW'(1);
            case (state)
                ST_IDLE: begin
                    // The deciding idle cycle counts as the first refresh cycle.
                    if (rfsh_due) begin
                        if (RFSH_LEN <= 1) begin
                            rfsh_cnt <= '0;
                        end else begin
                            state <= ST_RFSH;
                            cnt   <= RFSH_LOAD;
                        end
                    end else if (pick_ok) begin
                        state <= ST_ACK;
                        bank  <= pick_bank;
                        addr  <= pick_addr;
                        we    <= (pick_bank == 2'd0) && ba_wr;
                        din   <= ba0_din;
                        din_m <= ba0_din_m;
                    end
                end
                ST_ACK: begin
                    ptr  <= bank + 2'd1;
                    beat <= 1'b0;
                    if (LAT <= 1) begin
                        state <= ST_DATA;
                        if (!we)
                            data_read <= mem[{bank, addr}];
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 16'd0) begin
                        state <= ST_DATA;
                        if (!we)
                            data_read <= mem[{bank, addr}];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (last_word) begin
                        state <= ST_IDLE;
                    end else begin
                        beat      <= 1'b1;
                        addr      <= addr + AW'(1);
                        data_read <= mem[{bank, addr + AW'(1)}];
                    end
                end
                ST_RFSH: begin
                    if (cnt == 16'd0) begin
                        state    <= ST_IDLE;
                        rfsh_cnt <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_DATA && we) begin
            if (din_m[0])
                mem[{bank, addr}][7:0] <= din[7:0];
            if (din_m[1])
                mem[{bank, addr}][15:8] <= din[15:8];
        end
    end

    assign ba_ack = (state == ST_ACK) ? sel : 4'd0;
    assign ba_dok = (state == ST_DATA) ? sel : 4'd0;
    assign ba_dst = (state == ST_DATA && !beat) ? sel : 4'd0;
    assign ba_rdy = (state == ST_DATA && last_word) ? sel : 4'd0;

endmodule

// File: tb/tb_jtcop_sdram_resp.sv
// Bench for jtcop_sdram_resp: directed scenarios plus random requests, all checked
// cycle by cycle against a transaction-schedule model of the responder.
module tb_jtcop_sdram_resp;

    localparam int AW       = 10;
    localparam int LAT      = 3;
    localparam int BURST    = 2;
    localparam int RFSH     = 16;
    localparam int RFSH_LEN = 4;
    localparam int DEPTH    = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic [3:0]  ba_rd;
    logic        ba_wr;
    logic [15:0] ba0_din;
    logic [1:0]  ba0_din_m;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;

    jtcop_sdram_resp #(.AW(AW), .LAT(LAT), .BURST(BURST), .RFSH(RFSH), .RFSH_LEN(RFSH_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, busy window length, refresh age, pointer, and
    // a ring of expected strobes per future cycle.
    logic [15:0] mem_m [4][DEPTH];
    int          busy = 0;
    int          rf = 0;
    longint      clear_at = -1;
    logic [1:0]  ptr_m = 2'd0;
    longint      cyc = 0;
    logic [3:0]  e_ack [16];
    logic [3:0]  e_dst [16];
    logic [3:0]  e_dok [16];
    logic [3:0]  e_rdy [16];
    logic        e_dv  [16];
    logic        e_wr  [16];
    logic [15:0] e_val [16];
    int          w_addr;
    logic [15:0] w_din;
    logic [1:0]  w_m;
    logic [15:0] hold = 16'd0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_slot(input int s);
        e_ack[s] = 4'd0; e_dst[s] = 4'd0; e_dok[s] = 4'd0; e_rdy[s] = 4'd0;
        e_dv[s] = 1'b0; e_wr[s] = 1'b0; e_val[s] = 16'd0;
    endtask

    function automatic int bank_addr(input int b);
        logic [21:0] a;
        case (b)
            0:       a = ba0_addr;
            1:       a = ba1_addr;
            2:       a = ba2_addr;
            default: a = ba3_addr;
        endcase
        return int'(a) % DEPTH;
    endfunction

    // Decide what the responder does with this cycle's inputs.
    task automatic model_step();
        int          nrf;
        int          b, a, k;
        logic        found;
        logic [3:0]  req;
        if (!rst_n) begin
            busy = 0; rf = 0; clear_at = -1; ptr_m = 2'd0; hold = 16'd0;
            for (int s = 0; s < 16; s++) clear_slot(s);
            return;
        end
        nrf = (rf < RFSH) ? rf + 1 : rf;
        if (cyc == clear_at) nrf = 0;
        if (busy > 0) begin
            busy--;
        end else if (rf == RFSH) begin
            busy = RFSH_LEN - 1;
            clear_at = cyc + RFSH_LEN - 1;
            if (clear_at == cyc) nrf = 0;
        end else begin
            req = {ba_rd[3:1], ba_rd[0] | ba_wr};
            found = 1'b0; b = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && req[(int'(ptr_m) + i) % 4]) begin
                    found = 1'b1;
                    b = (int'(ptr_m) + i) % 4;
                end
            end
            if (found) begin
                ptr_m = 2'((b + 1) % 4);
                a = bank_addr(b);
                e_ack[int'((cyc + 1) % 16)] = 4'b0001 << b;
                if (b == 0 && ba_wr) begin
                    k = int'((cyc + 1 + LAT) % 16);
                    e_dst[k] = 4'b0001; e_dok[k] = 4'b0001; e_rdy[k] = 4'b0001; e_wr[k] = 1'b1;
                    w_addr = a; w_din = ba0_din; w_m = ba0_din_m;
                    busy = LAT + 1;
                end else begin
                    for (int j = 0; j < BURST; j++) begin
                        k = int'((cyc + 1 + LAT + j) % 16);
                        e_dok[k] = 4'b0001 << b;
                        e_dv[k] = 1'b1;
                        e_val[k] = mem_m[b][(a + j) % DEPTH];
                        if (j == 0) e_dst[k] = 4'b0001 << b;
                        if (j == BURST - 1) e_rdy[k] = 4'b0001 << b;
                    end
                    busy = LAT + BURST;
                end
            end
        end
        rf = nrf;
    endtask

    // One clock: model decision, edge, compare every output, requester drops acked levels.
    task automatic tick();
        int s;
        logic [3:0] acked;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        s = int'(cyc % 16);
        if (e_dv[s]) hold = e_val[s];
        chk("ack", 32'(ba_ack), 32'(e_ack[s]));
        chk("dst", 32'(ba_dst), 32'(e_dst[s]));
        chk("dok", 32'(ba_dok), 32'(e_dok[s]));
        chk("rdy", 32'(ba_rdy), 32'(e_rdy[s]));
        chk("data", 32'(data_read), 32'(hold));
        if (e_wr[s]) begin
            if (w_m[0]) mem_m[0][w_addr][7:0]  = w_din[7:0];
            if (w_m[1]) mem_m[0][w_addr][15:8] = w_din[15:8];
        end
        acked = e_ack[s];
        clear_slot(s);
        ba_rd = ba_rd & ~acked;
        if (acked[0]) ba_wr = 1'b0;
    endtask

    task automatic wait_ack(input int b, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (ba_ack[b] !== 1'b1 && waited < 64);
        chk("ack_arrives", 32'(waited < 64), 32'd1);
    endtask

    int          w, n, guard;
    int          order [5];
    logic [15:0] v;
    logic        pend;
    logic [21:0] ra;

    initial begin
        rst_n = 1'b0; ba_rd = 4'hF; ba_wr = 1'b0;
        ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
        ba0_din = '0; ba0_din_m = '0;
        for (int s = 0; s < 16; s++) clear_slot(s);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = 16'($urandom);
                if (b == 2 && i == 'h100) v = 16'h1234;
                if (b == 2 && i == 'h101) v = 16'h5678;
                if (b == 0 && i == 5)     v = 16'h1111;
                mem_m[b][i] = v;
                dut.mem[b * DEPTH + i] <= v;
            end
        end

        // Reset held with all reads requested.
        repeat (5) tick();
        chk("rst_ack", 32'(ba_ack), 32'd0);
        chk("rst_data", 32'(data_read), 32'd0);
        rst_n = 1'b1; ba_rd = 4'd0;
        repeat (2) tick();

        // Bank 2 burst read at 0x100, high address bits aliased away.
        ba2_addr = {12'($urandom), 10'h100};
        ba_rd[2] = 1'b1;
        wait_ack(2, w);
        repeat (LAT) tick();
        chk("b2_dst", 32'(ba_dst), 32'h4);
        chk("b2_word0", 32'(data_read), 32'h1234);
        tick();
        chk("b2_rdy", 32'(ba_rdy), 32'h4);
        chk("b2_word1", 32'(data_read), 32'h5678);
        repeat (2) tick();

        // Round-robin order from pointer 0.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ba_rd = 4'b1110;
        n = 0; guard = 0;
        for (int i = 0; i < 5; i++) order[i] = 7;
        while (n < 5 && guard < 120) begin
            tick();
            guard++;
            if (ba_ack != 4'd0) begin
                for (int i = 0; i < 4; i++) if (ba_ack[i]) order[n] = i;
                n++;
                if (n == 3) ba_rd = ba_rd | 4'b0011;
            end
        end
        chk("rr_0", 32'(order[0]), 32'd1);
        chk("rr_1", 32'(order[1]), 32'd2);
        chk("rr_2", 32'(order[2]), 32'd3);
        chk("rr_3", 32'(order[3]), 32'd0);
        chk("rr_4", 32'(order[4]), 32'd1);
        repeat (8) tick();

        // Masked write to bank 0 then readback.
        ba0_addr = {12'($urandom), 10'd5};
        ba0_din = 16'hABCD; ba0_din_m = 2'b01; ba_wr = 1'b1;
        wait_ack(0, w);
        repeat (LAT) tick();
        chk("wr_strobes", 32'({ba_dst, ba_dok, ba_rdy}), 32'h111);
        ba_rd[0] = 1'b1;
        wait_ack(0, w);
        repeat (LAT) tick();
        chk("wr_readback", 32'(data_read), 32'h11CD);
        repeat (3) tick();

        // Request raised exactly in the refresh-due idle cycle.
        guard = 0;
        while (!(busy == 0 && rf == RFSH) && guard < 64) begin
            tick();
            guard++;
        end
        chk("rfsh_found", 32'(guard < 64), 32'd1);
        ba_rd[1] = 1'b1;
        wait_ack(1, w);
        chk("rfsh_ack_delay", 32'(w - 1), 32'(RFSH_LEN));
        repeat (6) tick();

        // Burst wraps at the top of bank 3.
        ba3_addr = {12'($urandom), 10'(DEPTH - 1)};
        ba_rd[3] = 1'b1;
        wait_ack(3, w);
        repeat (LAT) tick();
        chk("wrap_word0", 32'(data_read), 32'(mem_m[3][DEPTH-1]));
        tick();
        chk("wrap_word1", 32'(data_read), 32'(mem_m[3][0]));
        repeat (2) tick();

        // Reset between ack and data aborts silently.
        ba1_addr = 22'($urandom);
        ba_rd[1] = 1'b1;
        wait_ack(1, w);
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_dok", 32'({ba_dok, ba_rdy}), 32'd0);
        end
        ba_rd[1] = 1'b1;
        wait_ack(1, w);
        repeat (LAT) tick();
        chk("after_abort_dok", 32'(ba_dok), 32'h2);
        chk("after_abort_data", 32'(data_read), 32'(mem_m[1][int'(ba1_addr) % DEPTH]));
        repeat (3) tick();

        // Random traffic, occasional drops and resets.
        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            for (int b = 0; b < 4; b++) begin
                pend = (b == 0) ? (ba_rd[0] | ba_wr) : ba_rd[b];
                if (pend && $urandom_range(0, 49) == 0) begin
                    ba_rd[b] = 1'b0;
                    if (b == 0) ba_wr = 1'b0;
                end else if (!pend && $urandom_range(0, 5) == 0) begin
                    ra = 22'($urandom);
                    case (b)
                        0:       ba0_addr = ra;
                        1:       ba1_addr = ra;
                        2:       ba2_addr = ra;
                        default: ba3_addr = ra;
                    endcase
                    if (b == 0 && $urandom_range(0, 1) == 1) begin
                        ba_wr = 1'b1;
                        ba0_din = 16'($urandom);
                        ba0_din_m = 2'($urandom);
                    end else begin
                        ba_rd[b] = 1'b1;
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1; ba_rd = 4'd0; ba_wr = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
